// File: rtl/bram_stream_reader.sv
// Burst reader for BRAM port B, presenting words as a valid/ready stream with a
// small skid FIFO. Define BRAM_OREG_EN when the BRAM output register is enabled.
module bram_stream_reader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 7
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addrb,
  output logic              enb,
  input  logic [DATA_W-1:0] doutb,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

`ifdef BRAM_OREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif
  localparam int FIFO_DEPTH = RD_LAT + 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);
  localparam logic [CNT_W:0]   CREDITS = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  beats;
  logic [LEN_W-1:0]  head_idx;
  logic [LEN_W-1:0]  clamped_len;

  logic [RD_LAT-1:0] rd_pipe;
  logic              ret_valid;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W:0]    credit_used;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fire;
  logic              bypass;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    outstanding = '0;
    for (int i = 0; i < RD_LAT; i++) outstanding += CNT_W'(rd_pipe[i]);
  end

  assign clamped_len = (len > MAX_LEN) ? MAX_LEN : len;
  assign ret_valid   = rd_pipe[RD_LAT-1];
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
  assign fifo_empty  = (fifo_count == '0);

  assign busy  = (state != IDLE);
  assign addrb = cur_addr;
  assign enb   = (state == RUN) && (remaining != '0) && (credit_used < CREDITS);

  // The word returning from the BRAM this cycle acts as the FIFO entry stage:
  // it is shown directly when the FIFO is empty and only stored if not taken.
  assign m_valid = !fifo_empty || ret_valid;
  assign m_data  = !fifo_empty ? fifo_mem[rd_ptr] : (ret_valid ? doutb : '0);
  assign m_last  = m_valid && (head_idx == beats - LEN_W'(1));
  assign fire    = m_valid && m_ready;
  assign bypass  = fifo_empty && ret_valid && m_ready;
  assign push    = ret_valid && !bypass;
  assign pop     = !fifo_empty && m_ready;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= doutb;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_pipe    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      rd_pipe <= (rd_pipe << 1) | RD_LAT'(enb);
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Burst sequencing; done is registered so it pulses the cycle after DONE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      beats     <= '0;
      head_idx  <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            cur_addr  <= start_addr;
            remaining <= clamped_len;
            beats     <= clamped_len;
            state     <= (clamped_len != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (enb) begin
            cur_addr  <= cur_addr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty && outstanding == '0 && head_idx == beats) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (state == IDLE && start) head_idx <= '0;
      else if (fire)              head_idx <= head_idx + 1'b1;
    end
  end

endmodule
